byte_joiner: RTL
================

BYTE_JOINER -- requirements
Module: byte_joiner

Interface
- REQ-001: Parameter LSB_FIRST, default 0, byte order: 0 = first accepted byte lands in out_word[31:24]; 1 = first byte lands in out_word[7:0].
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: reset  input  1  asynchronous, active-low reset.
- REQ-004: in_valid  input  1  in_byte carries a valid byte.
- REQ-005: in_byte  input  8  byte to pack.
- REQ-006: in_ready  output  1  block accepts in_byte this cycle.
- REQ-007: clear  input  1  synchronous discard of the partially assembled word.
- REQ-008: out_valid  output  1  out_word holds a complete word.
- REQ-009: out_word  output  32  assembled word, stable while out_valid=1 and out_ready=0.
- REQ-010: out_ready  input  1  consumer takes out_word this cycle.
- REQ-011: fill  output  2  number of bytes held in the accumulator (0..3).

Function
- REQ-012: An input handshake occurs when in_valid=1 and in_ready=1 on a rising edge; an output handshake occurs when out_valid=1 and out_ready=1.
- REQ-013: The accumulator stores bytes 1..3 and fill counts them; fill increments by 1 per input handshake for bytes 1..3.
- REQ-014: in_ready = (fill<3) | ~out_valid | out_ready, combinational; bytes 1..3 are accepted even while the holding register is full.
- REQ-015: On the 4th input handshake, out_word is loaded with the 3 accumulated bytes plus in_byte in LSB_FIRST order, out_valid becomes 1 on the next edge, and fill wraps to 0.
- REQ-016: Latency: out_valid is asserted the cycle after the 4th byte handshake; throughput is 1 byte/cycle sustained with out_ready held at 1.
- REQ-017: Output handshake with no simultaneous load clears out_valid; output handshake with a simultaneous 4th-byte load keeps out_valid=1 and updates out_word (back-to-back words, no bubble).
- REQ-018: out_word and out_valid do not change while out_valid=1 and out_ready=0.
- REQ-019: clear=1 forces fill to 0 and ignores any in_byte that cycle (in_ready is still driven per REQ-014 but no byte is stored); it does not alter out_valid or out_word.
- REQ-020: The block contains no combinational path from in_byte to out_word.

Reset
- REQ-021: reset=0 immediately forces out_valid=0, out_word=32'h0, fill=0 and accumulator=0, independent of clk.
- REQ-022: Reset asserted mid-word discards the partial word; the first byte after reset release is treated as byte 1.
- REQ-023: After reset release, in_ready=1.

Configuration
- REQ-024: Macro BYTE_JOINER_WCNT_EN, when defined, adds output word_cnt (16 bits); word_cnt increments by 1 per output handshake, wraps 16'hFFFF->0, and resets to 0.
- REQ-025: Without BYTE_JOINER_WCNT_EN, port word_cnt and its counter are absent; all other behaviour is identical.

Verification
- REQ-026: LSB_FIRST=0, out_ready=1, bytes 12,34,56,78 on consecutive cycles -> one cycle later out_valid=1, out_word=32'h12345678, fill=0.
- REQ-027: LSB_FIRST=1, same bytes -> out_word=32'h78563412.
- REQ-028: out_ready=0, stream 8 bytes AA..B1 -> first word held, fill reaches 3, in_ready drops to 0 with the 8th byte pending; raising out_ready -> word 32'hAAABACAD taken, then 32'hAEAFB0B1 appears the next cycle.
- REQ-029: out_ready=1, continuous 12-byte stream -> 3 words with out_valid high on 3 separated single cycles, no byte lost and in_ready constantly 1.
- REQ-030: After 2 bytes, pulse clear, then send 01,02,03,04 -> out_word=32'h01020304; repeat with reset pulsed instead of clear -> same result and out_valid=0 during reset.
- REQ-031: With BYTE_JOINER_WCNT_EN, 65537 words -> word_cnt=1.

Source files
------------

// File: rtl/byte_joiner.sv
//==============================================================================
// Module   : byte_joiner
// Purpose  : Packs a stream of bytes into 32-bit words with valid/ready
//            handshakes on both sides. Bytes 1..3 wait in an accumulator,
//            and the 4th byte loads the complete word into a holding register.
// Options  : BYTE_JOINER_WCNT_EN adds a 16-bit counter of output handshakes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module byte_joiner #(
    parameter int LSB_FIRST = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    input  logic        clear,
    output logic        out_valid,
    output logic [31:0] out_word,
    input  logic        out_ready,
`ifdef BYTE_JOINER_WCNT_EN
    output logic [15:0] word_cnt,
`endif
    output logic [1:0]  fill
);

    logic [1:0]       fill_q, fill_d;
    logic [2:0][7:0]  acc_q, acc_d;
    logic [31:0]      word_q, word_d;
    logic             valid_q, valid_d;
    logic             in_hs, out_hs;
    logic [31:0]      full_word;

    // The 4th byte may be taken only if the holding register is free or is
    // being emptied in this same cycle.
    assign in_ready = (fill_q != 2'd3) | ~valid_q | out_ready;
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = valid_q & out_ready;

    // Word image formed from the three stored bytes and the incoming 4th byte
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign full_word = {in_byte, acc_q[2], acc_q[1], acc_q[0]};
        end else begin : g_msb_first
            assign full_word = {acc_q[0], acc_q[1], acc_q[2], in_byte};
        end
    endgenerate

    // Next-state logic for accumulator, fill count and holding register
    always_comb begin
        fill_d  = fill_q;
        acc_d   = acc_q;
        word_d  = word_q;
        valid_d = valid_q;
        if (out_hs) begin
            valid_d = 1'b0;
        end
        if (clear) begin
            fill_d = 2'd0;
        end else if (in_hs) begin
            if (fill_q == 2'd3) begin
                word_d  = full_word;
                valid_d = 1'b1;
                fill_d  = 2'd0;
            end else begin
                case (fill_q)
                    2'd0:    acc_d[0] = in_byte;
                    2'd1:    acc_d[1] = in_byte;
                    default: acc_d[2] = in_byte;
                endcase
                fill_d = fill_q + 2'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q  <= 2'd0;
            acc_q   <= '0;
            word_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_word  = word_q;
    assign fill      = fill_q;

`ifdef BYTE_JOINER_WCNT_EN
    logic [15:0] wcnt_q;

    // Count completed output handshakes, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q <= 16'h0;
        end else if (out_hs) begin
            wcnt_q <= wcnt_q + 16'h1;
        end
    end

    assign word_cnt = wcnt_q;
`endif

endmodule

`default_nettype wire
